xaui_link_ctrl: RTL and testbench
=================================

# xaui_link_ctrl

Per-port XAUI link bring-up and supervision controller that sits between a 10GbE core and one four-lane channel of `xaui_infrastructure`. It sequences MGT resets, comma alignment and channel bonding, then declares link up. It watches lock, sync, buffer and code-valid status and retrains the link on loss. One instance is built per enabled port.

## Interface
Parameters:
- `RST_CYCLES`, default 64: cycles for which `mgt_tx_rst` and `mgt_rx_rst` are held high in RESET.
- `LOCK_TIMEOUT`, default 65535: maximum WAIT_LOCK cycles before a retry.
- `ALIGN_TIMEOUT`, default 65535: maximum cycles in ALIGN, and separately in SYNC, before a retry.
- `ALIGN_HOLD`, default 16: number of consecutive all-valid cycles needed to leave ALIGN.
- `ERR_THRESH`, default 8: number of consecutive bad-code cycles in UP that force a retrain.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `xaui_clk` in 1: clock.
  - `reset` in 1: synchronous, active-high reset.
- Control and MGT side:
  - `enable` in 1: run the link; low forces IDLE.
  - `mgt_tx_rst` out 1: TX reset to the MGT.
  - `mgt_rx_rst` out 1: RX reset to the MGT.
  - `mgt_rxlock` in 4: per-lane CDR lock.
  - `mgt_rxencommaalign` out 4: per-lane comma-align enable.
  - `mgt_rxenchansync` out 1: channel-bond enable.
  - `mgt_rxsyncok` in 4: per-lane bonding done.
  - `mgt_rxcodevalid` in 8: per-byte 8b/10b code valid.
  - `mgt_rxbufferr` in 4: per-lane elastic buffer error.
- Status outputs:
  - `link_up` out 1: link usable.
  - `state` out 3: current state encoding.
  - `retry_count` out 8: saturating retrain counter.
  - `err_count` out 16: saturating count of bad-code cycles while UP.

## Operation
State encoding: IDLE=0, RESET=1, WAIT_LOCK=2, ALIGN=3, SYNC=4, UP=5. A single cycle timer is cleared on every state entry.

- IDLE: both resets high, all enables 0. Moves to RESET when `enable`=1.
- RESET: both resets high. After `RST_CYCLES` cycles, moves to WAIT_LOCK.
- WAIT_LOCK: resets low.
  - `mgt_rxlock`==4'hF moves to ALIGN.
  - Timer reaching `LOCK_TIMEOUT` moves to RESET and increments `retry_count`.
- ALIGN: `mgt_rxencommaalign`=4'hF.
  - A run counter counts consecutive cycles with `mgt_rxcodevalid`==8'hFF and clears on any other value.
  - Run counter reaching `ALIGN_HOLD` moves to SYNC.
  - Timer reaching `ALIGN_TIMEOUT` causes a retry (RESET, `retry_count`+1).
- SYNC: `mgt_rxencommaalign`=4'hF and `mgt_rxenchansync`=1.
  - `mgt_rxsyncok`==4'hF moves to UP.
  - Timeout causes a retry.
- UP: `link_up`=1, `mgt_rxencommaalign`=0, `mgt_rxenchansync`=1.
  - Each cycle with `mgt_rxcodevalid`!=8'hFF increments `err_count`.
  - `ERR_THRESH` consecutive bad cycles cause a retry.
  - Any of the following causes an immediate retry: `mgt_rxlock`!=4'hF, `mgt_rxbufferr`!=0, or `mgt_rxsyncok`!=4'hF.
- Whenever `enable`=0, the next state is IDLE. This overrides all other transitions and does not count as a retry.
- When several retry causes occur in the same cycle, `retry_count` increments once.
- Both counters saturate: `retry_count` at 255, `err_count` at 65535. Only `reset` clears them; IDLE does not.
- Any out-of-range state encoding goes to IDLE.

## Timing
- All outputs are registered. Outputs reflect the current state and change in the same cycle that `state` changes.
- Reset values: `state`=0, `mgt_tx_rst`=1, `mgt_rx_rst`=1, `mgt_rxencommaalign`=0, `mgt_rxenchansync`=0, `link_up`=0, `retry_count`=0, `err_count`=0.
- `reset` asserted in any state returns to IDLE on the next edge and clears all counters and timers.
- Resets stay asserted for exactly `RST_CYCLES` cycles in RESET, plus the IDLE cycles before it.
- Input conditions are sampled at the edge. A satisfied condition takes effect one cycle later.
- Example: `mgt_rxlock`=4'hF sampled at edge N gives `state`=ALIGN after edge N+1.
- Minimum `enable`-to-`link_up` latency: 1 + `RST_CYCLES` + 1 + `ALIGN_HOLD` + 1 + 1 cycles with ideal inputs.
- Loss of link in UP drops `link_up` one cycle after the offending sample.

## Structure
- Shared package `xaui_link_pkg` holds:
  - the state enum (3-bit) with the encodings above;
  - width constants `XAUI_LANES`=4 and `XAUI_BYTES`=8;
  - counter widths (retry 8, err 16, timer 16).
- One sub-module, `xaui_link_timer`: a loadable up-counter with clear, a terminal-compare output and a parameterised width. It is instanced for the state timer; the run counters stay inline.

## Test plan
Bench parameters: `RST_CYCLES`=8, `LOCK_TIMEOUT`=32, `ALIGN_TIMEOUT`=32, `ALIGN_HOLD`=4, `ERR_THRESH`=3.
- Ideal bring-up:
  - Stimulus: `enable`=1 with lock, codevalid=FF and syncok=F present from the start.
  - Required response: `mgt_rx_rst` high for exactly 8 cycles; `link_up`=1 at the first cycle the latency formula gives; `retry_count`=0.
- Lock timeout:
  - Stimulus: `mgt_rxlock`=4'h7 held.
  - Required response: after 32 WAIT_LOCK cycles, state returns to RESET; `retry_count` reads 1, then 2 on the next timeout.
- ALIGN run reset:
  - Stimulus: codevalid pattern FF,FF,FF,7F,FF,FF,FF,FF.
  - Required response: SYNC entered only after the final 4 consecutive FF cycles.
- Error handling in UP:
  - Stimulus: 2 bad cycles, then 1 good, then 3 bad.
  - Required response: `err_count`=5; retrain only after the third consecutive bad cycle; `link_up`=0 the next cycle.
- Simultaneous causes and precedence:
  - Stimulus: `mgt_rxbufferr`=4'h1 and `mgt_rxlock`=4'hE in the same UP cycle.
  - Required response: one retry (`retry_count`+1).
  - Stimulus: `enable`=0 in that same cycle instead.
  - Required response: IDLE, `retry_count` unchanged.
- Saturation and reset mid-operation:
  - Stimulus: force 300 retries, then assert `reset` during SYNC.
  - Required response: `retry_count` holds at 255; the cycle after reset, all outputs are at their reset values.

Source files
------------

// File: rtl/xaui_link_pkg.sv
// Shared types and widths for the XAUI link bring-up controller.
package xaui_link_pkg;

  localparam int XAUI_LANES = 4;
  localparam int XAUI_BYTES = 8;
  localparam int RETRY_W    = 8;
  localparam int ERR_W      = 16;
  localparam int TIMER_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_ALIGN     = 3'd3,
    ST_SYNC      = 3'd4,
    ST_UP        = 3'd5
  } link_state_e;

  function automatic logic [RETRY_W-1:0] sat_inc_retry(input logic [RETRY_W-1:0] v);
    return (v == {RETRY_W{1'b1}}) ? v : v + RETRY_W'(1);
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/xaui_link_if.sv
// Control, MGT and status signals between the link controller and its environment.
interface xaui_link_if;
  import xaui_link_pkg::*;

  logic                    enable;
  logic                    mgt_tx_rst;
  logic                    mgt_rx_rst;
  logic [XAUI_LANES-1:0]   mgt_rxlock;
  logic [XAUI_LANES-1:0]   mgt_rxencommaalign;
  logic                    mgt_rxenchansync;
  logic [XAUI_LANES-1:0]   mgt_rxsyncok;
  logic [XAUI_BYTES-1:0]   mgt_rxcodevalid;
  logic [XAUI_LANES-1:0]   mgt_rxbufferr;
  logic                    link_up;
  logic [2:0]              state;
  logic [RETRY_W-1:0]      retry_count;
  logic [ERR_W-1:0]        err_count;

  modport master (
    input  enable, mgt_rxlock, mgt_rxsyncok, mgt_rxcodevalid, mgt_rxbufferr,
    output mgt_tx_rst, mgt_rx_rst, mgt_rxencommaalign, mgt_rxenchansync,
           link_up, state, retry_count, err_count
  );

  modport slave (
    output enable, mgt_rxlock, mgt_rxsyncok, mgt_rxcodevalid, mgt_rxbufferr,
    input  mgt_tx_rst, mgt_rx_rst, mgt_rxencommaalign, mgt_rxenchansync,
           link_up, state, retry_count, err_count
  );

endinterface

// File: rtl/xaui_link_timer.sv
// Loadable up-counter with clear and a terminal-count compare.
module xaui_link_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/xaui_link_ctrl.sv
// Per-port XAUI bring-up FSM: MGT reset, lock wait, comma align, bonding, link supervision.
module xaui_link_ctrl
  import xaui_link_pkg::*;
#(
  parameter int RST_CYCLES    = 64,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int ALIGN_TIMEOUT = 65535,
  parameter int ALIGN_HOLD    = 16,
  parameter int ERR_THRESH    = 8
) (
  input  logic        xaui_clk,
  input  logic        reset,
  xaui_link_if.master lnk
);

  localparam logic [TIMER_W-1:0] RST_TERM   = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_TERM  = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] ALIGN_TERM = TIMER_W'(ALIGN_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] HOLD_TERM  = TIMER_W'(ALIGN_HOLD - 1);
  localparam logic [TIMER_W-1:0] ERR_TERM   = TIMER_W'(ERR_THRESH - 1);

  link_state_e             state_q, state_d, next_s;
  logic                    en_q;
  logic [XAUI_LANES-1:0]   lock_q, sync_q, buf_q;
  logic [XAUI_BYTES-1:0]   cv_q;
  logic [TIMER_W-1:0]      run_q, run_d, bad_q, bad_d, tmr_term_s;
  logic [RETRY_W-1:0]      retry_q, retry_d;
  logic [ERR_W-1:0]        err_q, err_d;
  logic                    tx_rst_q, tx_rst_d, rx_rst_q, rx_rst_d;
  logic [XAUI_LANES-1:0]   comma_q, comma_d;
  logic                    chsync_q, chsync_d, link_up_q, link_up_d;
  logic                    tmr_tc_s, cause_s, lock_ok_s, sync_ok_s, cv_ok_s, entry_s;

  assign lock_ok_s = (lock_q == {XAUI_LANES{1'b1}});
  assign sync_ok_s = (sync_q == {XAUI_LANES{1'b1}});
  assign cv_ok_s   = (cv_q == {XAUI_BYTES{1'b1}});
  assign entry_s   = (state_d != state_q);

  always_comb begin
    tmr_term_s = ALIGN_TERM;
    case (state_q)
      ST_RESET:     tmr_term_s = RST_TERM;
      ST_WAIT_LOCK: tmr_term_s = LOCK_TERM;
      default:      tmr_term_s = ALIGN_TERM;
    endcase
  end

  xaui_link_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk_i      (xaui_clk),
    .rst_i      (reset),
    .clr_i      (entry_s),
    .load_i     (1'b0),
    .load_val_i ({TIMER_W{1'b0}}),
    .en_i       (1'b1),
    .term_i     (tmr_term_s),
    .tc_o       (tmr_tc_s)
  );

  // Success paths take precedence over a timeout landing in the same cycle.
  always_comb begin
    next_s  = state_q;
    cause_s = 1'b0;
    case (state_q)
      ST_IDLE:      if (en_q) next_s = ST_RESET; else next_s = ST_IDLE;
      ST_RESET:     if (tmr_tc_s) next_s = ST_WAIT_LOCK; else next_s = ST_RESET;
      ST_WAIT_LOCK: if (lock_ok_s) next_s = ST_ALIGN; else cause_s = tmr_tc_s;
      ST_ALIGN:     if (cv_ok_s && run_q == HOLD_TERM) next_s = ST_SYNC; else cause_s = tmr_tc_s;
      ST_SYNC:      if (sync_ok_s) next_s = ST_UP; else cause_s = tmr_tc_s;
      ST_UP:        cause_s = !lock_ok_s || (buf_q != '0) || !sync_ok_s ||
                              (!cv_ok_s && bad_q == ERR_TERM);
      default:      next_s = ST_IDLE;
    endcase

    if (!en_q)        state_d = ST_IDLE;
    else if (cause_s) state_d = ST_RESET;
    else              state_d = next_s;

    if (en_q && cause_s) retry_d = sat_inc_retry(retry_q);
    else                 retry_d = retry_q;
    if (state_q == ST_UP && !cv_ok_s) err_d = sat_inc_err(err_q);
    else                              err_d = err_q;

    if (entry_s)      run_d = '0;
    else if (cv_ok_s) run_d = run_q + TIMER_W'(1);
    else              run_d = '0;
    if (entry_s)      bad_d = '0;
    else if (cv_ok_s) bad_d = '0;
    else              bad_d = bad_q + TIMER_W'(1);

    // Outputs are decoded from the next state so they move together with state.
    tx_rst_d  = (state_d == ST_IDLE) || (state_d == ST_RESET);
    rx_rst_d  = tx_rst_d;
    comma_d   = ((state_d == ST_ALIGN) || (state_d == ST_SYNC)) ? {XAUI_LANES{1'b1}} : '0;
    chsync_d  = (state_d == ST_SYNC) || (state_d == ST_UP);
    link_up_d = (state_d == ST_UP);
  end

  always_ff @(posedge xaui_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      lock_q    <= '0;
      sync_q    <= '0;
      buf_q     <= '0;
      cv_q      <= '0;
      run_q     <= '0;
      bad_q     <= '0;
      retry_q   <= '0;
      err_q     <= '0;
      tx_rst_q  <= 1'b1;
      rx_rst_q  <= 1'b1;
      comma_q   <= '0;
      chsync_q  <= 1'b0;
      link_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= lnk.enable;
      lock_q    <= lnk.mgt_rxlock;
      sync_q    <= lnk.mgt_rxsyncok;
      buf_q     <= lnk.mgt_rxbufferr;
      cv_q      <= lnk.mgt_rxcodevalid;
      run_q     <= run_d;
      bad_q     <= bad_d;
      retry_q   <= retry_d;
      err_q     <= err_d;
      tx_rst_q  <= tx_rst_d;
      rx_rst_q  <= rx_rst_d;
      comma_q   <= comma_d;
      chsync_q  <= chsync_d;
      link_up_q <= link_up_d;
    end
  end

  assign lnk.state              = state_q;
  assign lnk.mgt_tx_rst         = tx_rst_q;
  assign lnk.mgt_rx_rst         = rx_rst_q;
  assign lnk.mgt_rxencommaalign = comma_q;
  assign lnk.mgt_rxenchansync   = chsync_q;
  assign lnk.link_up            = link_up_q;
  assign lnk.retry_count        = retry_q;
  assign lnk.err_count          = err_q;

endmodule

// File: tb/tb_xaui_link_ctrl.sv
// Scoreboard bench for xaui_link_ctrl with a history-based reference model.
module tb_xaui_link_ctrl;
  import xaui_link_pkg::*;

  localparam int RST_C   = 8;
  localparam int LOCK_T  = 32;
  localparam int ALIGN_T = 32;
  localparam int HOLD    = 4;
  localparam int THRESH  = 3;

  logic xaui_clk = 1'b0;
  logic reset    = 1'b1;

  xaui_link_if lnk();

  xaui_link_ctrl #(
    .RST_CYCLES(RST_C), .LOCK_TIMEOUT(LOCK_T), .ALIGN_TIMEOUT(ALIGN_T),
    .ALIGN_HOLD(HOLD), .ERR_THRESH(THRESH)
  ) dut (
    .xaui_clk (xaui_clk),
    .reset    (reset),
    .lnk      (lnk)
  );

  always #5 xaui_clk = ~xaui_clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        txr;
    logic        rxr;
    logic [3:0]  comma;
    logic        chs;
    logic        up;
    logic [7:0]  retry;
    logic [15:0] err;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   started = 1'b0;

  // Reference model: state, counters, samples taken at the previous edge,
  // and the per-cycle codevalid history since the current state was entered.
  int         m_st = 0, m_retry = 0, m_err = 0;
  bit         p_en = 1'b0;
  logic [3:0] p_lock = 4'h0, p_sync = 4'h0, p_buf = 4'h0;
  logic [7:0] p_cv = 8'h00;
  bit         hist[$];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit tail_is(input int n, input bit v);
    if (hist.size() < n) return 1'b0;
    for (int k = hist.size() - n; k < hist.size(); k++)
      if (hist[k] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_tick();
    int nxt;
    int t;
    bit cause;
    bit ok;
    if (reset) begin
      m_st = 0; m_retry = 0; m_err = 0;
      hist.delete();
    end else begin
      ok    = (p_cv == 8'hFF);
      t     = hist.size();
      nxt   = m_st;
      cause = 1'b0;
      hist.push_back(ok);
      case (m_st)
        0: if (p_en) nxt = 1;
        1: if (t == RST_C - 1) nxt = 2;
        2: if (p_lock == 4'hF) nxt = 3; else cause = (t == LOCK_T - 1);
        3: if (tail_is(HOLD, 1'b1)) nxt = 4; else cause = (t == ALIGN_T - 1);
        4: if (p_sync == 4'hF) nxt = 5; else cause = (t == ALIGN_T - 1);
        5: cause = (p_lock != 4'hF) || (p_buf != 4'h0) || (p_sync != 4'hF) ||
                   tail_is(THRESH, 1'b0);
        default: nxt = 0;
      endcase
      if (m_st == 5 && !ok && m_err < 65535) m_err++;
      if (p_en && cause && m_retry < 255) m_retry++;
      if (!p_en)      nxt = 0;
      else if (cause) nxt = 1;
      if (nxt != m_st) hist.delete();
      m_st = nxt;
    end
    if (reset) begin
      p_en = 1'b0; p_lock = 4'h0; p_sync = 4'h0; p_buf = 4'h0; p_cv = 8'h00;
    end else begin
      p_en = lnk.enable; p_lock = lnk.mgt_rxlock; p_sync = lnk.mgt_rxsyncok;
      p_buf = lnk.mgt_rxbufferr; p_cv = lnk.mgt_rxcodevalid;
    end
  endtask

  function automatic obs_t expect_obs();
    obs_t e;
    e.st    = 3'(m_st);
    e.txr   = (m_st <= 1);
    e.rxr   = (m_st <= 1);
    e.comma = (m_st == 3 || m_st == 4) ? 4'hF : 4'h0;
    e.chs   = (m_st == 4 || m_st == 5);
    e.up    = (m_st == 5);
    e.retry = 8'(m_retry);
    e.err   = 16'(m_err);
    return e;
  endfunction

  // Predict the effect of the upcoming edge, queue it, then advance to the next negedge.
  task automatic step();
    model_tick();
    exp_q.push_back(expect_obs());
    started = 1'b1;
    @(negedge xaui_clk);
  endtask

  task automatic drive(input bit en, input logic [3:0] lock, input logic [7:0] cv,
                       input logic [3:0] sync, input logic [3:0] bufe);
    lnk.enable = en; lnk.mgt_rxlock = lock; lnk.mgt_rxcodevalid = cv;
    lnk.mgt_rxsyncok = sync; lnk.mgt_rxbufferr = bufe;
  endtask

  task automatic run_until_state(input int st, input int bound, input string name);
    int n;
    n = 0;
    while (m_st != st && n < bound) begin step(); n++; end
    if (m_st != st) chk(name, m_st, st);
  endtask

  // Monitor: compare every DUT output against the queued prediction just after each edge.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge xaui_clk);
      #1;
      if (started) begin
        a = {lnk.state, lnk.mgt_tx_rst, lnk.mgt_rx_rst, lnk.mgt_rxencommaalign,
             lnk.mgt_rxenchansync, lnk.link_up, lnk.retry_count, lnk.err_count};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_underflow: got %h expected a queued entry", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            bad++;
            $display("FAIL outputs @%0t: got st=%0d rst=%b%b comma=%h chs=%b up=%b retry=%0d err=%0d expected st=%0d rst=%b%b comma=%h chs=%b up=%b retry=%0d err=%0d",
                     $time, a.st, a.txr, a.rxr, a.comma, a.chs, a.up, a.retry, a.err,
                     e.st, e.txr, e.rxr, e.comma, e.chs, e.up, e.retry, e.err);
          end
        end
      end
    end
  end

  initial begin
    int n, rc, wl;
    logic [7:0] pat [8];
    logic [7:0] errseq [6];
    pat    = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    errseq = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};

    drive(1'b0, 4'h0, 8'h00, 4'h0, 4'h0);
    reset = 1'b1;
    @(negedge xaui_clk);
    step(); step();
    reset = 1'b0;
    step();

    // Ideal bring-up: latency and RESET duration.
    drive(1'b1, 4'hF, 8'hFF, 4'hF, 4'h0);
    n = 0; rc = 0;
    while (lnk.link_up !== 1'b1 && n < 60) begin
      step(); n++;
      if (lnk.state == 3'd1 && lnk.mgt_rx_rst === 1'b1) rc++;
    end
    chk("bringup_latency", n, 16);
    chk("rx_rst_cycles", rc, 8);
    chk("bringup_retry", lnk.retry_count, 0);

    // Lock timeout twice.
    reset = 1'b1; step(); reset = 1'b0;
    drive(1'b1, 4'h7, 8'hFF, 4'hF, 4'h0);
    n = 0; wl = 0;
    while (m_retry < 1 && n < 200) begin
      step(); n++;
      if (lnk.state == 3'd2) wl++;
    end
    chk("lock_wait_cycles", wl, 32);
    chk("lock_retry1", lnk.retry_count, 1);
    chk("lock_back_to_reset", lnk.state, 1);
    n = 0;
    while (m_retry < 2 && n < 200) begin step(); n++; end
    chk("lock_retry2", lnk.retry_count, 2);

    // ALIGN run counter restart on a bad codevalid.
    reset = 1'b1; step(); reset = 1'b0;
    drive(1'b1, 4'hF, 8'h00, 4'h0, 4'h0);
    run_until_state(3, 100, "reach_align");
    for (int i = 0; i < 8; i++) begin
      lnk.mgt_rxcodevalid = pat[i];
      step();
      chk("align_no_early_sync", lnk.state == 3'd4, 0);
    end
    step();
    chk("align_enter_sync", lnk.state, 4);

    // Bad-code errors while UP.
    reset = 1'b1; step(); reset = 1'b0;
    drive(1'b1, 4'hF, 8'hFF, 4'hF, 4'h0);
    run_until_state(5, 60, "reach_up");
    step(); step();
    for (int i = 0; i < 6; i++) begin
      lnk.mgt_rxcodevalid = errseq[i];
      step();
    end
    chk("err_link_still_up", lnk.link_up, 1);
    lnk.mgt_rxcodevalid = 8'hFF;
    step();
    chk("err_link_dropped", lnk.link_up, 0);
    chk("err_count", lnk.err_count, 5);
    chk("err_retry", lnk.retry_count, 1);

    // Two loss causes in one cycle count once; enable low wins without a retry.
    run_until_state(5, 80, "reach_up2");
    lnk.mgt_rxbufferr = 4'h1; lnk.mgt_rxlock = 4'hE;
    step();
    drive(1'b1, 4'hF, 8'hFF, 4'hF, 4'h0);
    step();
    chk("simul_one_retry", lnk.retry_count, 2);
    chk("simul_state_reset", lnk.state, 1);
    run_until_state(5, 80, "reach_up3");
    drive(1'b0, 4'hE, 8'hFF, 4'hF, 4'h1);
    step();
    drive(1'b0, 4'hF, 8'hFF, 4'hF, 4'h0);
    step();
    chk("disable_idle", lnk.state, 0);
    chk("disable_no_retry", lnk.retry_count, 2);

    // Saturate the retry counter, then reset during SYNC.
    drive(1'b1, 4'h7, 8'hFF, 4'hF, 4'h0);
    repeat (300 * 40 + 40) step();
    chk("retry_saturated", lnk.retry_count, 255);
    drive(1'b1, 4'hF, 8'hFF, 4'h0, 4'h0);
    run_until_state(4, 100, "reach_sync");
    step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_state", lnk.state, 0);
    chk("rst_resets", {lnk.mgt_tx_rst, lnk.mgt_rx_rst}, 2'b11);
    chk("rst_enables", {lnk.mgt_rxencommaalign, lnk.mgt_rxenchansync, lnk.link_up}, 0);
    chk("rst_counters", {lnk.retry_count, lnk.err_count}, 0);

    // Randomised operation.
    for (int i = 0; i < 3000; i++) begin
      reset               = ($urandom_range(0, 199) == 0);
      lnk.enable          = ($urandom_range(0, 49) != 0);
      lnk.mgt_rxlock      = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'hF;
      lnk.mgt_rxcodevalid = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF;
      lnk.mgt_rxsyncok    = ($urandom_range(0, 14) == 0) ? 4'($urandom) : 4'hF;
      lnk.mgt_rxbufferr   = ($urandom_range(0, 59) == 0) ? 4'($urandom) : 4'h0;
      step();
    end
    reset = 1'b0;

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
